serial_operand_loader: RTL

- Serial front end for the 8-bit adder datapath; the receiving end of the LSB-first bit-serial scheme the result display uses.
- Operator sets one data switch per bit and presses a shift button to clock the bit in. A load button commits operand A, then operand B.
- Once both operands are committed, it presents them to the adder with a valid/ready handshake.

---
 rtl/serial_operand_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/serial_operand_loader.sv
// Bit-serial operand entry: synchronized, debounced shift/load buttons assemble
// two WIDTH-bit operands LSB-first and present them with a valid/ready handshake.
module serial_operand_loader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sdata,
    input  logic             shiftsignal,
    input  logic             loadsignal,
    input  logic             op_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    output logic [WIDTH-1:0] preview,
    output logic [3:0]       bit_cnt,
    output logic [1:0]       phase,
    output logic             err
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [3:0]  FULL  = 4'(WIDTH);

    typedef enum logic [1:0] {
        COLLECT_A = 2'd0,
        COLLECT_B = 2'd1,
        HOLD      = 2'd2
    } phase_t;

    logic             rst_meta, rst_n;
    logic [2:0]       sync1, sync2;
    logic             sdata_s;
    logic [1:0]       btn_s;
    logic [1:0]       db_level, db_level_d, press_p;
    logic [CNT_W-1:0] db_cnt [2];
    logic             shift_p, load_p;

    phase_t           state, state_n;
    logic [WIDTH-1:0] op_a_n, op_b_n, preview_n;
    logic [3:0]       bit_cnt_n;
    logic             op_valid_n, err_n;

    // Reset asserts immediately, releases two clocks later on a clean edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    assign sdata_s = sync2[0];
    assign btn_s   = sync2[2:1];
    assign shift_p = press_p[0];
    assign load_p  = press_p[1];

    // Two-flop synchronizers, then per-button debounce and rising-edge press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            db_level   <= '0;
            db_level_d <= '0;
            press_p    <= '0;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            sync1 <= {loadsignal, shiftsignal, sdata};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (btn_s[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    db_level[i] <= ~db_level[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
            db_level_d <= db_level;
            press_p    <= db_level & ~db_level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT_A;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            preview  <= '0;
            bit_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            op_a     <= op_a_n;
            op_b     <= op_b_n;
            op_valid <= op_valid_n;
            preview  <= preview_n;
            bit_cnt  <= bit_cnt_n;
            err      <= err_n;
        end
    end

    assign phase = state;

    // Load wins over a coincident shift; the dropped shift is flagged.
    always_comb begin
        state_n    = state;
        op_a_n     = op_a;
        op_b_n     = op_b;
        op_valid_n = op_valid;
        preview_n  = preview;
        bit_cnt_n  = bit_cnt;
        err_n      = 1'b0;
        case (state)
            COLLECT_A, COLLECT_B: begin
                if (load_p) begin
                    if (shift_p) err_n = 1'b1;
                    if (bit_cnt == FULL) begin
                        if (state == COLLECT_A) begin
                            op_a_n  = preview;
                            state_n = COLLECT_B;
                        end else begin
                            op_b_n     = preview;
                            op_valid_n = 1'b1;
                            state_n    = HOLD;
                        end
                        preview_n = '0;
                        bit_cnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (shift_p) begin
                    if (bit_cnt < FULL) begin
                        preview_n = {sdata_s, preview[WIDTH-1:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                err_n = shift_p | load_p;
                if (op_valid && op_ready) begin
                    op_valid_n = 1'b0;
                    state_n    = COLLECT_A;
                end
            end
            default: state_n = COLLECT_A;
        endcase
    end

endmodule
